player_input_ctrl: RTL and testbench

//  Parametrised successor to the player front-panel controller. Per-button debounce, auto-repeat on

---
 rtl/player_ctrl_pkg.sv | 28 ++
 rtl/btn_debounce_rep.sv | 102 ++++++++++
 rtl/player_input_ctrl.sv | 191 +++++++++++++++++++
 tb/tb_player_input_ctrl.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/player_ctrl_pkg.sv
// Shared definitions for the player front-panel controller:
// button indices, FSM state types and default volume constants.
package player_ctrl_pkg;

    localparam int BTN_C = 0;
    localparam int BTN_U = 1;
    localparam int BTN_D = 2;
    localparam int BTN_L = 3;
    localparam int BTN_R = 4;
    localparam int N_BTN = 5;

    localparam logic [7:0] VOL_DEF_P  = 8'h40;
    localparam logic [7:0] VOL_STEP_P = 8'h10;
    localparam logic [7:0] VOL_MAX_P  = 8'hF0;

    typedef enum logic [1:0] {
        R_IDLE,
        R_HOLD,
        R_REPEAT
    } rep_state_t;

    typedef enum logic [1:0] {
        C_IDLE,
        C_HELD,
        C_LONG
    } cen_state_t;

endpackage

// File: rtl/btn_debounce_rep.sv
// One button: 2-FF synchroniser, debounce counter and optional
// auto-repeat FSM producing a one-cycle event pulse.
import player_ctrl_pkg::*;

module btn_debounce_rep #(
    parameter int DEB_CYCLES = 20,
    parameter int REP_DELAY  = 200,
    parameter int REP_PERIOD = 50,
    parameter bit REPEAT_EN  = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic raw,
    output logic level,
    output logic press
);

    localparam int DW   = $clog2(DEB_CYCLES + 1);
    localparam int RMAX = (REP_DELAY > REP_PERIOD) ? REP_DELAY : REP_PERIOD;
    localparam int RW   = $clog2(RMAX + 1);

    logic          sync1_q, sync2_q;
    logic [DW-1:0] deb_cnt_q, deb_cnt_d;
    logic          level_q, level_d;
    rep_state_t    st_q;
    logic [RW-1:0] rcnt_q;
    logic          press_q;

    // The counter only runs while the sample disagrees with the accepted level.
    always_comb begin
        deb_cnt_d = '0;
        level_d   = level_q;
        if (sync2_q != level_q) begin
            if (deb_cnt_q == DW'(DEB_CYCLES - 1)) begin
                level_d = sync2_q;
            end else begin
                deb_cnt_d = deb_cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q   <= 1'b0;
            sync2_q   <= 1'b0;
            deb_cnt_q <= '0;
            level_q   <= 1'b0;
        end else begin
            sync1_q   <= raw;
            sync2_q   <= sync1_q;
            deb_cnt_q <= deb_cnt_d;
            level_q   <= level_d;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            st_q    <= R_IDLE;
            rcnt_q  <= '0;
            press_q <= 1'b0;
        end else begin
            press_q <= 1'b0;
            unique case (st_q)
                R_IDLE: begin
                    if (level_q) begin
                        st_q    <= R_HOLD;
                        rcnt_q  <= '0;
                        press_q <= 1'b1;
                    end
                end
                R_HOLD: begin
                    if (!level_q) begin
                        st_q <= R_IDLE;
                    end else if (REPEAT_EN) begin
                        if (rcnt_q == RW'(REP_DELAY - 1)) begin
                            st_q    <= R_REPEAT;
                            rcnt_q  <= '0;
                            press_q <= 1'b1;
                        end else begin
                            rcnt_q <= rcnt_q + 1'b1;
                        end
                    end
                end
                R_REPEAT: begin
                    if (!level_q) begin
                        st_q <= R_IDLE;
                    end else if (rcnt_q == RW'(REP_PERIOD - 1)) begin
                        rcnt_q  <= '0;
                        press_q <= 1'b1;
                    end else begin
                        rcnt_q <= rcnt_q + 1'b1;
                    end
                end
                default: st_q <= R_IDLE;
            endcase
        end
    end

    assign level = level_q;
    assign press = press_q;

endmodule

// File: rtl/player_input_ctrl.sv
// Player front panel: debounced buttons with auto-repeat, centre short/long
// press, volume with mute, track select by buttons and switches.
import player_ctrl_pkg::*;

module player_input_ctrl #(
    parameter int N_TRACKS    = 8,
    parameter int N_SW        = 16,
    parameter int VOL_W       = 8,
    parameter logic [VOL_W-1:0] VOL_STEP = VOL_W'(VOL_STEP_P),
    parameter logic [VOL_W-1:0] VOL_MAX  = VOL_W'(VOL_MAX_P),
    parameter logic [VOL_W-1:0] VOL_DEF  = VOL_W'(VOL_DEF_P),
    parameter int DEB_CYCLES  = 20,
    parameter int REP_DELAY   = 200,
    parameter int REP_PERIOD  = 50,
    parameter int LONG_CYCLES = 400,
    localparam int TRK_W = (N_TRACKS > 1) ? $clog2(N_TRACKS) : 1
) (
    input  logic               CLK,
    input  logic               RST,
    input  logic               BTNC,
    input  logic               BTNU,
    input  logic               BTND,
    input  logic               BTNL,
    input  logic               BTNR,
    input  logic [N_SW-1:0]    SW,
    output logic [2*VOL_W-1:0] vol,
    output logic [TRK_W-1:0]   CURRENT,
    output logic               mute,
    output logic               track_chg
);

    localparam int LW = $clog2(LONG_CYCLES + 1);

    logic [N_BTN-1:0] btn_raw, btn_lvl, btn_ev;

    assign btn_raw[BTN_C] = BTNC;
    assign btn_raw[BTN_U] = BTNU;
    assign btn_raw[BTN_D] = BTND;
    assign btn_raw[BTN_L] = BTNL;
    assign btn_raw[BTN_R] = BTNR;

    for (genvar i = 0; i < N_BTN; i++) begin : g_btn
        btn_debounce_rep #(
            .DEB_CYCLES(DEB_CYCLES),
            .REP_DELAY (REP_DELAY),
            .REP_PERIOD(REP_PERIOD),
            .REPEAT_EN (i != BTN_C)
        ) u_btn (
            .clk  (CLK),
            .rst  (RST),
            .raw  (btn_raw[i]),
            .level(btn_lvl[i]),
            .press(btn_ev[i])
        );
    end

    cen_state_t    cst_q;
    logic [LW-1:0] lcnt_q;
    logic          tgl_q, restore_q;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            cst_q     <= C_IDLE;
            lcnt_q    <= '0;
            tgl_q     <= 1'b0;
            restore_q <= 1'b0;
        end else begin
            tgl_q     <= 1'b0;
            restore_q <= 1'b0;
            unique case (cst_q)
                C_IDLE: begin
                    if (btn_ev[BTN_C]) begin
                        cst_q  <= C_HELD;
                        lcnt_q <= '0;
                    end
                end
                C_HELD: begin
                    if (!btn_lvl[BTN_C]) begin
                        tgl_q <= 1'b1;
                        cst_q <= C_IDLE;
                    end else if (lcnt_q == LW'(LONG_CYCLES - 1)) begin
                        restore_q <= 1'b1;
                        cst_q     <= C_LONG;
                    end else begin
                        lcnt_q <= lcnt_q + 1'b1;
                    end
                end
                C_LONG: begin
                    if (!btn_lvl[BTN_C]) cst_q <= C_IDLE;
                end
                default: cst_q <= C_IDLE;
            endcase
        end
    end

    logic [N_SW-1:0]  sw1_q, sw2_q;
    logic [TRK_W-1:0] sw_enc;
    logic             sw_any, sw_apply;
    logic [TRK_W:0]   sel_q, sel_d;

    always_comb begin
        sw_enc = '0;
        for (int i = N_TRACKS - 1; i >= 0; i--) begin
            if (sw2_q[i]) sw_enc = TRK_W'(i);
        end
    end

    // The any-bit is part of the compared value so SW[0] after all-off still applies.
    assign sw_any   = |sw2_q[N_TRACKS-1:0];
    assign sel_d    = {sw_any, sw_enc};
    assign sw_apply = sw_any && (sel_d != sel_q);

    logic [VOL_W-1:0] lvl_q, lvl_d;
    logic             mute_q, mute_d;
    logic [TRK_W-1:0] cur_q, cur_d, nxt, prv;
    logic             chg_q, chg_d;
    logic [VOL_W:0]   up_sum, dn_dif;
    logic             up, dn, nx, pv;

    assign up = btn_ev[BTN_U];
    assign dn = btn_ev[BTN_D];
    assign nx = btn_ev[BTN_R];
    assign pv = btn_ev[BTN_L];

    assign up_sum = {1'b0, lvl_q} + {1'b0, VOL_STEP};
    assign dn_dif = {1'b0, lvl_q} - {1'b0, VOL_STEP};
    assign nxt = (cur_q == TRK_W'(N_TRACKS - 1)) ? '0 : cur_q + 1'b1;
    assign prv = (cur_q == '0) ? TRK_W'(N_TRACKS - 1) : cur_q - 1'b1;

    always_comb begin
        lvl_d  = lvl_q;
        mute_d = mute_q;
        if (restore_q) begin
            lvl_d  = VOL_DEF;
            mute_d = 1'b0;
        end else begin
            if (tgl_q) mute_d = !mute_q;
            if (up && !dn) begin
                mute_d = 1'b0;
                lvl_d  = (up_sum > {1'b0, VOL_MAX}) ? VOL_MAX : up_sum[VOL_W-1:0];
            end else if (dn && !up) begin
                mute_d = 1'b0;
                lvl_d  = dn_dif[VOL_W] ? '0 : dn_dif[VOL_W-1:0];
            end
        end
    end

    always_comb begin
        cur_d = cur_q;
        if (restore_q) begin
            cur_d = '0;
        end else if (sw_apply) begin
            cur_d = sw_enc;
        end else if (nx && !pv) begin
            cur_d = nxt;
        end else if (pv && !nx) begin
            cur_d = prv;
        end
    end

    assign chg_d = (cur_d != cur_q);

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            sw1_q  <= '0;
            sw2_q  <= '0;
            sel_q  <= '0;
            lvl_q  <= VOL_DEF;
            mute_q <= 1'b0;
            cur_q  <= '0;
            chg_q  <= 1'b0;
        end else begin
            sw1_q  <= SW;
            sw2_q  <= sw1_q;
            sel_q  <= sel_d;
            lvl_q  <= lvl_d;
            mute_q <= mute_d;
            cur_q  <= cur_d;
            chg_q  <= chg_d;
        end
    end

    logic unused_ok;
    assign unused_ok = ^{btn_lvl[BTN_R:BTN_U], sw2_q};

    assign vol       = mute_q ? '0 : {lvl_q, lvl_q};
    assign CURRENT   = cur_q;
    assign mute      = mute_q;
    assign track_chg = chg_q;

endmodule

// File: tb/tb_player_input_ctrl.sv
// Bench for player_input_ctrl: directed vector table, multi-cycle corner
// sequences and random button/switch actions against an action-level model.
module tb_player_input_ctrl;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic btnc = 1'b0, btnu = 1'b0, btnd = 1'b0, btnl = 1'b0, btnr = 1'b0;
    logic [15:0] sw = '0;
    logic [15:0] vol, vol5;
    logic [2:0]  cur, cur5;
    logic        mute, mute5, chg, chg5;

    int total = 0;
    int bad = 0;
    int chg_total = 0;

    always #5 clk = ~clk;

    player_input_ctrl #(
        .DEB_CYCLES(4), .REP_DELAY(20), .REP_PERIOD(5), .LONG_CYCLES(40)
    ) dut (
        .CLK(clk), .RST(rst), .BTNC(btnc), .BTNU(btnu), .BTND(btnd),
        .BTNL(btnl), .BTNR(btnr), .SW(sw), .vol(vol), .CURRENT(cur),
        .mute(mute), .track_chg(chg)
    );

    player_input_ctrl #(
        .N_TRACKS(5), .DEB_CYCLES(4), .REP_DELAY(20), .REP_PERIOD(5),
        .LONG_CYCLES(40)
    ) dut5 (
        .CLK(clk), .RST(rst), .BTNC(btnc), .BTNU(btnu), .BTND(btnd),
        .BTNL(btnl), .BTNR(btnr), .SW(sw), .vol(vol5), .CURRENT(cur5),
        .mute(mute5), .track_chg(chg5)
    );

    always @(posedge clk) begin
        #1;
        if (chg === 1'b1) chg_total = chg_total + 1;
    end

    typedef struct {
        logic [4:0]  m;
        logic [15:0] s;
        int          hold;
        logic [15:0] v;
        int          c;
        bit          mu;
        int          ch;
    } vec_t;

    vec_t tbl[15];

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic chk(input string nm, input logic [31:0] a,
                       input logic [31:0] e);
        total++;
        if (a !== e) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", nm, a, e);
        end
    endtask

    // mask bits are {R, L, D, U, C}
    task automatic act(input logic [4:0] m, input logic [15:0] s,
                       input int hold);
        sw = s;
        {btnr, btnl, btnd, btnu, btnc} = m;
        step(hold);
        {btnr, btnl, btnd, btnu, btnc} = '0;
        step(25);
    endtask

    int base;
    int mv, mc, msel, sel, r, hold;
    bit mm;
    logic [15:0] s;
    logic [4:0]  m;

    initial begin
        tbl[0]  = '{5'b00010, 16'h0000, 10,  16'h5050, 0, 1'b0, 0};
        tbl[1]  = '{5'b00001, 16'h0000, 10,  16'h0000, 0, 1'b1, 0};
        tbl[2]  = '{5'b00010, 16'h0000, 10,  16'h6060, 0, 1'b0, 0};
        tbl[3]  = '{5'b00100, 16'h0000, 10,  16'h5050, 0, 1'b0, 0};
        tbl[4]  = '{5'b01000, 16'h0000, 10,  16'h5050, 7, 1'b0, 1};
        tbl[5]  = '{5'b10000, 16'h0000, 10,  16'h5050, 0, 1'b0, 1};
        tbl[6]  = '{5'b11000, 16'h0000, 10,  16'h5050, 0, 1'b0, 0};
        tbl[7]  = '{5'b00000, 16'h0008, 0,   16'h5050, 3, 1'b0, 1};
        tbl[8]  = '{5'b10000, 16'h0008, 10,  16'h5050, 4, 1'b0, 1};
        tbl[9]  = '{5'b00000, 16'h000A, 0,   16'h5050, 1, 1'b0, 1};
        tbl[10] = '{5'b00000, 16'h0000, 0,   16'h5050, 1, 1'b0, 0};
        tbl[11] = '{5'b00010, 16'h0000, 200, 16'hF0F0, 1, 1'b0, 0};
        tbl[12] = '{5'b00100, 16'h0000, 200, 16'h0000, 1, 1'b0, 0};
        tbl[13] = '{5'b00001, 16'h0000, 60,  16'h4040, 0, 1'b0, 1};
        tbl[14] = '{5'b00110, 16'h0000, 10,  16'h4040, 0, 1'b0, 0};

        step(3);
        chk("rst_vol", vol, 16'h4040);
        chk("rst_cur", cur, 0);
        chk("rst_mute", mute, 0);
        rst = 1'b0;
        step(3);
        chk("post_rst_chg", chg, 0);
        chk("post_rst_vol", vol, 16'h4040);

        for (int i = 0; i < 15; i++) begin
            base = chg_total;
            act(tbl[i].m, tbl[i].s, tbl[i].hold);
            chk($sformatf("vec%0d_vol", i), vol, tbl[i].v);
            chk($sformatf("vec%0d_cur", i), cur, tbl[i].c);
            chk($sformatf("vec%0d_mute", i), mute, tbl[i].mu);
            chk($sformatf("vec%0d_chg", i), chg_total - base, tbl[i].ch);
        end

        // Bounce shorter than the debounce window must be ignored.
        for (int i = 0; i < 6; i++) begin
            btnu = ~btnu;
            step(2);
        end
        btnu = 1'b0;
        step(25);
        chk("bounce_vol", vol, 16'h4040);
        act(5'b00010, 16'h0, 10);
        chk("clean_vol", vol, 16'h5050);
        for (int i = 0; i < 9; i++) act(5'b00010, 16'h0, 10);
        chk("to_e0_vol", vol, 16'hE0E0);
        btnu = 1'b1;
        step(100);
        chk("sat_mid_vol", vol, 16'hF0F0);
        step(100);
        btnu = 1'b0;
        step(25);
        chk("sat_end_vol", vol, 16'hF0F0);
        for (int i = 0; i < 14; i++) act(5'b00100, 16'h0, 10);
        chk("to_10_vol", vol, 16'h1010);
        btnd = 1'b1;
        step(100);
        chk("floor_mid_vol", vol, 16'h0000);
        step(100);
        btnd = 1'b0;
        step(25);
        chk("floor_end_vol", vol, 16'h0000);

        // Five-track wrap, switches shared with the eight-track instance.
        act(5'b00000, 16'h0010, 0);
        chk("sw4_cur8", cur, 4);
        chk("sw4_cur5", cur5, 4);
        act(5'b10000, 16'h0010, 10);
        chk("next_cur8", cur, 5);
        chk("wrap_cur5", cur5, 0);
        act(5'b00000, 16'h0000, 0);
        chk("swoff_cur5", cur5, 0);

        // Long press restores once; a step taken while still held must survive.
        act(5'b00001, 16'h0, 10);
        chk("pre_long_mute", mute, 1);
        base = chg_total;
        btnc = 1'b1;
        step(60);
        btnu = 1'b1;
        step(10);
        btnu = 1'b0;
        step(30);
        btnc = 1'b0;
        step(25);
        chk("long_vol", vol, 16'h5050);
        chk("long_cur", cur, 0);
        chk("long_mute", mute, 0);
        chk("long_chg", chg_total - base, 1);

        // Asynchronous reset while a button is held.
        act(5'b10000, 16'h0, 10);
        btnu = 1'b1;
        step(50);
        #2;
        rst = 1'b1;
        #1;
        chk("arst_vol", vol, 16'h4040);
        chk("arst_cur", cur, 0);
        chk("arst_mute", mute, 0);
        chk("arst_chg", chg, 0);
        step(2);
        rst = 1'b0;
        step(10);
        btnu = 1'b0;
        step(25);
        chk("fresh_press_vol", vol, 16'h5050);

        mv = 8'h50;
        mm = 1'b0;
        mc = 0;
        msel = -1;
        s = '0;
        for (int n = 0; n < 40; n++) begin
            r = $urandom_range(0, 6);
            hold = $urandom_range(8, 14);
            m = '0;
            base = chg_total;
            sel = mc;
            case (r)
                0: begin
                    m = 5'b00010;
                    mm = 1'b0;
                    mv = (mv + 16 > 240) ? 240 : mv + 16;
                end
                1: begin
                    m = 5'b00100;
                    mm = 1'b0;
                    mv = (mv < 16) ? 0 : mv - 16;
                end
                2: begin
                    m = 5'b01000;
                    mc = (mc + 7) % 8;
                end
                3: begin
                    m = 5'b10000;
                    mc = (mc + 1) % 8;
                end
                4: begin
                    m = 5'b00001;
                    mm = !mm;
                end
                5: m = 5'b11000;
                default: begin
                    hold = 0;
                    s = 16'($urandom);
                    if ($urandom_range(0, 3) == 0) s[7:0] = '0;
                    sel = -1;
                    for (int i = 7; i >= 0; i--) if (s[i]) sel = i;
                    if (sel >= 0 && sel != msel) mc = sel;
                    msel = sel;
                    sel = -2;
                end
            endcase
            if (sel != -2) sel = -3;
            act(m, s, hold);
            chk($sformatf("rnd%0d_vol", n), vol,
                mm ? 16'h0 : {mv[7:0], mv[7:0]});
            chk($sformatf("rnd%0d_cur", n), cur, mc);
            chk($sformatf("rnd%0d_mute", n), mute, mm);
            chk($sformatf("rnd%0d_chg", n), chg_total - base,
                (cur === 3'(mc) && base != chg_total) ? 1 : 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
